// File: rtl/ss_pkg.sv
// Shared types and helpers for the signed stochastic-to-binary converter.
// Holds the FSM state encoding, the per-sample delta encoding and the saturation classifier.
package ss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } ss_state_e;

  typedef enum logic [1:0] {
    SAT_NONE = 2'b00,
    SAT_MAX  = 2'b01,
    SAT_MIN  = 2'b10
  } ss_sat_e;

  localparam logic signed [1:0] DELTA_ZERO = 2'sb00;
  localparam logic signed [1:0] DELTA_POS  = 2'sb01;
  localparam logic signed [1:0] DELTA_NEG  = 2'sb11;

  // Sign-magnitude stochastic bit to a signed step of -1, 0 or +1.
  function automatic logic signed [1:0] ss_delta(input logic in_bit, input logic sign_bit);
    logic signed [1:0] d;
    case ({in_bit, sign_bit})
      2'b10:   d = DELTA_POS;
      2'b11:   d = DELTA_NEG;
      default: d = DELTA_ZERO;
    endcase
    return d;
  endfunction

  // Classifies a signed sum against the two's-complement range of an out_w-bit result.
  function automatic ss_sat_e ss_sat(input logic signed [31:0] sum, input int unsigned out_w);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    ss_sat_e            r;
    max_v = (32'sd1 <<< (out_w - 32'd1)) - 32'sd1;
    min_v = -(32'sd1 <<< (out_w - 32'd1));
    if (sum > max_v) begin
      r = SAT_MAX;
    end else if (sum < min_v) begin
      r = SAT_MIN;
    end else begin
      r = SAT_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/ss_signed_stoch2bin_chk.sv
// Protocol checker for ss_signed_stoch2bin: strobe width, clamp values and BUSY/state agreement.
module ss_signed_stoch2bin_chk
  import ss_pkg::*;
#(
  parameter int OUT_W = 9
) (
  input logic             CLK,
  input logic             INIT,
  input logic             VALID,
  input logic             SAT,
  input logic             BUSY,
  input ss_state_e        state,
  input logic [OUT_W-1:0] VALUE
);

  localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  a_valid_one_cycle: assert property (@(posedge CLK) disable iff (INIT) VALID |=> !VALID);

  a_sat_clamped: assert property (@(posedge CLK) disable iff (INIT)
    (VALID && SAT) |-> ((VALUE == MAX_V) || (VALUE == MIN_V)));

  a_busy_matches_run: assert property (@(posedge CLK) disable iff (INIT)
    BUSY == (state == ST_RUN));

  a_state_legal: assert property (@(posedge CLK) disable iff (INIT)
    state != 2'b11);

endmodule

// File: rtl/ss_window_counter.sv
// Counts enabled samples within one window; TC flags the sample that closes the window.
// The counter wraps to zero on that sample, so a new window starts with no idle edge.
module ss_window_counter #(
  parameter int WIN_LOG2 = 8
) (
  input  logic CLK,
  input  logic INIT,
  input  logic CLR,
  input  logic EN,
  output logic TC
);

  logic [WIN_LOG2-1:0] cnt_r;

  // Sample counter with asynchronous init and synchronous clear.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      cnt_r <= '0;
    end else if (CLR) begin
      cnt_r <= '0;
    end else if (EN) begin
      cnt_r <= cnt_r + WIN_LOG2'(1);
    end
  end

  assign TC = EN && (cnt_r == {WIN_LOG2{1'b1}});

endmodule

// File: rtl/ss_signed_stoch2bin.sv
// Signed stochastic-to-binary converter: integrates a sign-magnitude bitstream over
// 2^WIN_LOG2 enabled samples and emits a saturated two's-complement value per window.
module ss_signed_stoch2bin
  import ss_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int OUT_W    = 9
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             EN,
  input  logic             IN,
  input  logic             SIGN,
  input  logic             SINGLE,
  input  logic             RESTART,
  output logic [OUT_W-1:0] VALUE,
  output logic             VALID,
  output logic             SAT,
  output logic             BUSY
);

  localparam int ACC_W = WIN_LOG2 + 2;

  ss_state_e               state_r;
  ss_state_e               state_nxt_s;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] delta_s;
  logic signed [ACC_W-1:0] sum_s;
  logic                    sample_s;
  logic                    win_end_s;
  ss_sat_e                 sat_kind_s;
  logic [OUT_W-1:0]        value_nxt_s;
  logic [OUT_W-1:0]        value_r;
  logic                    valid_r;
  logic                    sat_r;
  logic                    busy_r;

  // HOLD ignores EN and RESTART discards a coincident sample.
  assign sample_s = EN && (state_r != ST_HOLD) && !RESTART;

  ss_window_counter #(
    .WIN_LOG2(WIN_LOG2)
  ) u_win_cnt (
    .CLK (CLK),
    .INIT(INIT),
    .CLR (RESTART),
    .EN  (sample_s),
    .TC  (win_end_s)
  );

  // Delta, running sum and saturated window result.
  always_comb begin
    delta_s     = ACC_W'(ss_delta(IN, SIGN));
    sum_s       = acc_r + delta_s;
    sat_kind_s  = ss_sat(32'(sum_s), OUT_W);
    value_nxt_s = sum_s[OUT_W-1:0];
    case (sat_kind_s)
      SAT_MAX: value_nxt_s = {1'b0, {(OUT_W-1){1'b1}}};
      SAT_MIN: value_nxt_s = {1'b1, {(OUT_W-1){1'b0}}};
      default: value_nxt_s = sum_s[OUT_W-1:0];
    endcase
  end

  // Next-state logic; RESTART wins over everything else.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (RESTART) begin
          state_nxt_s = ST_IDLE;
        end else if (EN) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (RESTART) begin
          state_nxt_s = ST_IDLE;
        end else if (win_end_s) begin
          state_nxt_s = SINGLE ? ST_HOLD : ST_RUN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (RESTART) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Window accumulator; restarts from zero after every window end or RESTART.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      acc_r <= '0;
    end else if (RESTART || win_end_s) begin
      acc_r <= '0;
    end else if (sample_s) begin
      acc_r <= sum_s;
    end
  end

  // Output registers; win_end_s is already suppressed by RESTART.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      value_r <= '0;
      valid_r <= 1'b0;
      sat_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= win_end_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      if (win_end_s) begin
        value_r <= value_nxt_s;
        sat_r   <= (sat_kind_s != SAT_NONE);
      end
    end
  end

  assign VALUE = value_r;
  assign VALID = valid_r;
  assign SAT   = sat_r;
  assign BUSY  = busy_r;

  ss_signed_stoch2bin_chk #(
    .OUT_W(OUT_W)
  ) u_chk (
    .CLK  (CLK),
    .INIT (INIT),
    .VALID(valid_r),
    .SAT  (sat_r),
    .BUSY (busy_r),
    .state(state_r),
    .VALUE(value_r)
  );

endmodule
